// File: rtl/icache_refill_if.sv
// icache_refill_if: miss, memory-read and line-delivery signals of the refill engine
interface icache_refill_if #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int BLOCK_WIDTH = 3
);
   localparam int LINE_WIDTH = (1 << BLOCK_WIDTH) * DATA_WIDTH;
   logic                  miss_req;
   logic [ADDR_WIDTH-1:0] miss_addr;
   logic                  miss_ready;
   logic                  mem_req;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_ack;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_err;
   logic                  line_valid;
   logic                  line_err;
   logic [ADDR_WIDTH-1:0] line_addr;
   logic [LINE_WIDTH-1:0] line_data;
   modport master (
      output miss_req, miss_addr, mem_ack, mem_rdata, mem_err,
      input  miss_ready, mem_req, mem_addr, line_valid, line_err, line_addr, line_data
   );
   modport slave (
      input  miss_req, miss_addr, mem_ack, mem_rdata, mem_err,
      output miss_ready, mem_req, mem_addr, line_valid, line_err, line_addr, line_data
   );
endinterface

// File: rtl/icache_refill.sv
// icache_refill: fetches one cache line as sequential word reads and delivers it whole
module icache_refill #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int BLOCK_WIDTH = 3
) (
   input logic clk,
   input logic rst,
   icache_refill_if.slave bus
);
   localparam int BLOCK_SIZE = 1 << BLOCK_WIDTH;
   localparam int LINE_WIDTH = BLOCK_SIZE * DATA_WIDTH;
   localparam int OFFS_WIDTH = BLOCK_WIDTH + 2;
   typedef enum logic [1:0] {IDLE, FILL, DONE, ERR} state_t;
   state_t                 state, state_nx;
   logic [BLOCK_WIDTH-1:0] cnt;
   logic [ADDR_WIDTH-1:0]  line_addr;
   logic [LINE_WIDTH-1:0]  line_data;
   logic                   last;
   logic                   accept;
   logic                   word_ok;
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   always_comb begin
      last           = cnt == BLOCK_WIDTH'(BLOCK_SIZE - 1);
      accept         = state == IDLE && bus.miss_req;
      word_ok        = state == FILL && bus.mem_ack && !bus.mem_err;
      state_nx       = state == IDLE ? (bus.miss_req ? FILL : IDLE)
                     : state == FILL ? (!bus.mem_ack ? FILL : bus.mem_err ? ERR : last ? DONE : FILL)
                     : IDLE;
      bus.miss_ready = state == IDLE;
      bus.mem_req    = state == FILL;
      bus.line_valid = state == DONE;
      bus.line_err   = state == ERR;
      bus.mem_addr   = line_addr + ADDR_WIDTH'({cnt, 2'b00});
      bus.line_addr  = line_addr;
      bus.line_data  = line_data;
   end
   // The counter wraps to zero after the last word, ready for the next fill.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         cnt       <= '0;
         line_addr <= '0;
         line_data <= '0;
      end else if (accept) begin
         cnt       <= '0;
         line_addr <= {bus.miss_addr[ADDR_WIDTH-1:OFFS_WIDTH], {OFFS_WIDTH{1'b0}}};
      end else if (word_ok) begin
         cnt                             <= cnt + BLOCK_WIDTH'(1);
         line_data[cnt*DATA_WIDTH +: DATA_WIDTH] <= bus.mem_rdata;
      end
endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: directed scenarios for the line-fill engine
module tb_icache_refill;
   logic clk = 0;
   logic rst = 0;
   int   errors = 0;
   int   checks = 0;
   icache_refill_if bus ();
   icache_refill dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 0;
      bus.miss_req = 0; bus.miss_addr = 0; bus.mem_ack = 0; bus.mem_rdata = 0; bus.mem_err = 0;
      #3;
      checks++; if (bus.miss_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.miss_ready); end
      checks++; if ({bus.mem_req, bus.line_valid, bus.line_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {bus.mem_req, bus.line_valid, bus.line_err}); end
      checks++; if (bus.mem_addr !== 32'h0 || bus.line_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h/%h want 0/0", bus.mem_addr, bus.line_addr); end
      checks++; if (bus.line_data !== 256'h0) begin errors++; $display("FAIL reset_data got %h want 0", bus.line_data); end
      tick;
      rst = 1;
      tick;
   endtask

   task automatic test_zero_wait;
      int cyc = 0;
      bus.miss_req = 1; bus.miss_addr = 32'h0000_1234;
      tick;
      bus.miss_req = 0;
      for (int i = 0; i < 8; i++) begin
         cyc++;
         checks++; if (bus.mem_req !== 1'b1 || bus.miss_ready !== 1'b0) begin errors++; $display("FAIL zw_req word %0d got req=%b ready=%b want 1/0", i, bus.mem_req, bus.miss_ready); end
         checks++; if (bus.mem_addr !== 32'h1220 + 4 * i) begin errors++; $display("FAIL zw_addr word %0d got %h want %h", i, bus.mem_addr, 32'h1220 + 4 * i); end
         bus.mem_ack = 1; bus.mem_rdata = 32'h1220 + 4 * i;
         tick;
      end
      bus.mem_ack = 0;
      cyc++;
      checks++; if (bus.line_valid !== 1'b1 || cyc != 9) begin errors++; $display("FAIL zw_valid got %b at cycle %0d want 1 at 9", bus.line_valid, cyc); end
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL zw_done_req got %b want 0", bus.mem_req); end
      checks++; if (bus.line_addr !== 32'h1220) begin errors++; $display("FAIL zw_line_addr got %h want 00001220", bus.line_addr); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (bus.line_data[i*32 +: 32] !== 32'h1220 + 4 * i) begin errors++; $display("FAIL zw_word %0d got %h want %h", i, bus.line_data[i*32 +: 32], 32'h1220 + 4 * i); end
      end
      tick;
      checks++; if (bus.line_valid !== 1'b0 || bus.miss_ready !== 1'b1) begin errors++; $display("FAIL zw_after got valid=%b ready=%b want 0/1", bus.line_valid, bus.miss_ready); end
      checks++; if (bus.line_data[7*32 +: 32] !== 32'h123C || bus.line_addr !== 32'h1220) begin errors++; $display("FAIL zw_hold got %h/%h want 0000123c/00001220", bus.line_data[7*32 +: 32], bus.line_addr); end
   endtask

   task automatic test_wait_states;
      int bad = 0;
      bus.miss_req = 1; bus.miss_addr = 32'h0000_1234;
      tick;
      bus.miss_req = 0;
      for (int i = 0; i < 8; i++) begin
         for (int w = 0; w < 4; w++) begin
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h1220 + 4 * i) bad++;
            bus.mem_ack = (w == 3); bus.mem_rdata = (w == 3) ? 32'hA000_0000 + i : 32'hFFFF_FFFF;
            tick;
         end
      end
      bus.mem_ack = 0;
      checks++; if (bad != 0) begin errors++; $display("FAIL ws_addr_stable got %0d bad cycles want 0", bad); end
      checks++; if (bus.line_valid !== 1'b1) begin errors++; $display("FAIL ws_valid got %b want 1 after 8th ack", bus.line_valid); end
      checks++; if (bus.line_data[3*32 +: 32] !== 32'hA000_0003 || bus.line_data[7*32 +: 32] !== 32'hA000_0007) begin errors++; $display("FAIL ws_data got %h/%h want a0000003/a0000007", bus.line_data[3*32 +: 32], bus.line_data[7*32 +: 32]); end
      tick;
      checks++; if (bus.line_valid !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL ws_pulse got valid=%b req=%b want 0/0", bus.line_valid, bus.mem_req); end
   endtask

   task automatic test_bus_error;
      bus.miss_req = 1; bus.miss_addr = 32'h0000_1234;
      tick;
      bus.miss_req = 0;
      for (int i = 0; i < 6; i++) begin
         bus.mem_ack = 1; bus.mem_err = (i == 5); bus.mem_rdata = (i == 5) ? 32'hDEAD_BEEF : 32'hB000_0000 + i;
         tick;
      end
      bus.mem_ack = 0; bus.mem_err = 0;
      checks++; if (bus.line_err !== 1'b1 || bus.line_valid !== 1'b0) begin errors++; $display("FAIL err_pulse got err=%b valid=%b want 1/0", bus.line_err, bus.line_valid); end
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL err_req got %b want 0", bus.mem_req); end
      checks++; if (bus.line_data[4*32 +: 32] !== 32'hB000_0004 || bus.line_data[5*32 +: 32] !== 32'hA000_0005) begin errors++; $display("FAIL err_data got %h/%h want b0000004/a0000005", bus.line_data[4*32 +: 32], bus.line_data[5*32 +: 32]); end
      tick;
      checks++; if (bus.miss_ready !== 1'b1 || bus.line_err !== 1'b0 || bus.line_valid !== 1'b0) begin errors++; $display("FAIL err_after got ready=%b err=%b valid=%b want 1/0/0", bus.miss_ready, bus.line_err, bus.line_valid); end
   endtask

   task automatic test_reset_mid_fill;
      bus.miss_req = 1; bus.miss_addr = 32'h0000_1234;
      tick;
      bus.miss_req = 0;
      for (int i = 0; i < 4; i++) begin
         bus.mem_ack = 1; bus.mem_rdata = 32'hC000_0000 + i;
         tick;
      end
      bus.mem_ack = 0;
      rst = 0;
      #1;
      checks++; if (bus.mem_req !== 1'b0 || bus.miss_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ctrl got req=%b ready=%b want 0/1", bus.mem_req, bus.miss_ready); end
      checks++; if (bus.line_data !== 256'h0 || bus.line_addr !== 32'h0 || bus.mem_addr !== 32'h0) begin errors++; $display("FAIL mid_rst_clear got data=%h addr=%h maddr=%h want 0", bus.line_data, bus.line_addr, bus.mem_addr); end
      #1;
      rst = 1;
      tick;
      bus.miss_req = 1; bus.miss_addr = 32'h0000_2000;
      tick;
      bus.miss_req = 0;
      for (int i = 0; i < 8; i++) begin
         checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h2000 + 4 * i) begin errors++; $display("FAIL refill_addr word %0d got req=%b addr=%h want 1/%h", i, bus.mem_req, bus.mem_addr, 32'h2000 + 4 * i); end
         bus.mem_ack = 1; bus.mem_rdata = 32'hD000_0000 + i;
         tick;
      end
      bus.mem_ack = 0;
      checks++; if (bus.line_valid !== 1'b1 || bus.line_addr !== 32'h2000) begin errors++; $display("FAIL refill_valid got %b addr=%h want 1/00002000", bus.line_valid, bus.line_addr); end
      checks++; if (bus.line_data[0 +: 32] !== 32'hD000_0000 || bus.line_data[7*32 +: 32] !== 32'hD000_0007) begin errors++; $display("FAIL refill_data got %h/%h want d0000000/d0000007", bus.line_data[0 +: 32], bus.line_data[7*32 +: 32]); end
      tick;
   endtask

   task automatic test_back_to_back;
      bus.mem_ack = 1; bus.mem_rdata = 32'hEEEE_EEEE;
      tick;
      tick;
      bus.mem_ack = 0;
      checks++; if (bus.miss_ready !== 1'b1 || bus.mem_req !== 1'b0 || bus.line_valid !== 1'b0) begin errors++; $display("FAIL stray_ack got ready=%b req=%b valid=%b want 1/0/0", bus.miss_ready, bus.mem_req, bus.line_valid); end
      checks++; if (bus.line_data[0 +: 32] !== 32'hD000_0000) begin errors++; $display("FAIL stray_data got %h want d0000000", bus.line_data[0 +: 32]); end
      bus.miss_req = 1; bus.miss_addr = 32'h0000_3004;
      tick;
      bus.miss_addr = 32'h0000_4000;
      for (int i = 0; i < 8; i++) begin
         checks++; if (bus.miss_ready !== 1'b0 || bus.mem_addr !== 32'h3000 + 4 * i) begin errors++; $display("FAIL busy word %0d got ready=%b addr=%h want 0/%h", i, bus.miss_ready, bus.mem_addr, 32'h3000 + 4 * i); end
         bus.mem_ack = 1; bus.mem_rdata = i;
         tick;
      end
      bus.mem_ack = 0;
      checks++; if (bus.line_valid !== 1'b1 || bus.line_addr !== 32'h3000) begin errors++; $display("FAIL busy_valid got %b addr=%h want 1/00003000", bus.line_valid, bus.line_addr); end
      tick;
      checks++; if (bus.miss_ready !== 1'b1 || bus.line_addr !== 32'h3000) begin errors++; $display("FAIL second_idle got ready=%b addr=%h want 1/00003000", bus.miss_ready, bus.line_addr); end
      tick;
      bus.miss_req = 0;
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h4000 || bus.line_addr !== 32'h4000) begin errors++; $display("FAIL second_accept got req=%b addr=%h line=%h want 1/00004000/00004000", bus.mem_req, bus.mem_addr, bus.line_addr); end
   endtask

   initial begin
      test_reset;
      test_zero_wait;
      test_wait_states;
      test_bus_error;
      test_reset_mid_fill;
      test_back_to_back;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
